// File: rtl/vga_capture.sv
// VGA receive front end: samples RGB565 with h_sync/v_sync, rebuilds pixel coordinates
// and reports timing lock/errors. Define VGA_CAPTURE_CRC_EN to add a per-frame CRC-16 output.
module vga_capture #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_stb,
    input  logic [4:0]  vga_red,
    input  logic [5:0]  vga_green,
    input  logic [4:0]  vga_blue,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [15:0] pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS0     = H_SYNC + H_BP;
    localparam int VS0     = V_SYNC + V_BP;

    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] HS0_W     = 11'(HS0);
    localparam logic [10:0] HS1_W     = 11'(HS0 + H_ACTIVE);
    localparam logic [9:0]  VS0_W     = 10'(VS0);
    localparam logic [9:0]  VS1_W     = 10'(VS0 + V_ACTIVE);
    localparam logic [10:0] H_MAX_W   = 11'h7FF;
    localparam logic [9:0]  V_MAX_W   = 10'h3FF;
    localparam logic [1:0]  LOCK_MAX  = 2'd2;

    logic        prev_h_r;
    logic        prev_v_r;
    logic        seen_h_r;
    logic        seen_v_r;
    logic [10:0] h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [1:0]  lock_cnt_r;
    logic [1:0]  lock_nxt_s;
    logic        h_edge_s;
    logic        v_edge_s;
    logic [11:0] h_inc_s;
    logic [10:0] v_inc_s;
    logic        line_err_s;
    logic        frame_err_s;
    logic        active_s;
    logic [15:0] rgb_s;

    assign h_edge_s    = pix_stb & (h_sync == SYNC_ACTIVE) & (prev_h_r != SYNC_ACTIVE);
    assign v_edge_s    = pix_stb & (v_sync == SYNC_ACTIVE) & (prev_v_r != SYNC_ACTIVE);
    // Widened increments so a saturated counter still reads as a bad length.
    assign h_inc_s     = {1'b0, h_cnt_r} + 12'd1;
    assign v_inc_s     = {1'b0, v_cnt_r} + 11'd1;
    assign line_err_s  = h_edge_s & seen_h_r & (h_inc_s != H_TOTAL_W);
    assign frame_err_s = v_edge_s & seen_v_r & (v_inc_s != V_TOTAL_W);
    assign active_s    = pix_stb & seen_h_r & seen_v_r
                       & (h_cnt_r >= HS0_W) & (h_cnt_r < HS1_W)
                       & (v_cnt_r >= VS0_W) & (v_cnt_r < VS1_W);
    assign rgb_s       = {vga_red, vga_green, vga_blue};

    // Next lock count: any timing error clears it, good vsync intervals count up to two.
    always_comb begin
        lock_nxt_s = lock_cnt_r;
        if (line_err_s || frame_err_s) begin
            lock_nxt_s = 2'd0;
        end else if (v_edge_s && seen_v_r && (lock_cnt_r != LOCK_MAX)) begin
            lock_nxt_s = lock_cnt_r + 2'd1;
        end else begin
            lock_nxt_s = lock_cnt_r;
        end
    end

    // Sync edge history and saturating position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_h_r <= ~SYNC_ACTIVE;
            prev_v_r <= ~SYNC_ACTIVE;
            seen_h_r <= 1'b0;
            seen_v_r <= 1'b0;
            h_cnt_r  <= 11'd0;
            v_cnt_r  <= 10'd0;
        end else if (pix_stb) begin
            prev_h_r <= h_sync;
            prev_v_r <= v_sync;
            if (h_edge_s) begin
                h_cnt_r  <= 11'd0;
                seen_h_r <= 1'b1;
            end else if (h_cnt_r != H_MAX_W) begin
                h_cnt_r <= h_cnt_r + 11'd1;
            end
            // vsync wins over a coincident hsync for the line counter
            if (v_edge_s) begin
                v_cnt_r  <= 10'd0;
                seen_v_r <= 1'b1;
            end else if (h_edge_s && (v_cnt_r != V_MAX_W)) begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end
    end

    // Lock counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_r <= 2'd0;
        end else begin
            lock_cnt_r <= lock_nxt_s;
        end
    end

    // Registered pixel stream and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            pixel_rgb   <= 16'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pixel_valid <= active_s;
            frame_start <= active_s & (h_cnt_r == HS0_W) & (v_cnt_r == VS0_W);
            line_err    <= line_err_s;
            frame_err   <= frame_err_s;
            locked      <= (lock_nxt_s == LOCK_MAX);
            if (active_s) begin
                pixel_x   <= 10'(h_cnt_r - HS0_W);
                pixel_y   <= v_cnt_r - VS0_W;
                pixel_rgb <= rgb_s;
            end
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    localparam logic [9:0] X_LAST_W = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST_W = 10'(V_ACTIVE - 1);

    function automatic logic [15:0] crc16_ccitt(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_acc_r;
    logic [15:0] crc_next_s;

    // CRC step over the registered pixel, restarting from the seed on the first pixel.
    always_comb begin
        crc_next_s = crc16_ccitt((frame_start ? 16'hFFFF : crc_acc_r), pixel_rgb);
    end

    // Frame CRC accumulator and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_acc_r <= 16'd0;
            frame_crc <= 16'd0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (pixel_valid) begin
                crc_acc_r <= crc_next_s;
                if ((pixel_x == X_LAST_W) && (pixel_y == Y_LAST_W)) begin
                    frame_crc <= crc_next_s;
                    crc_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed self-checking bench for vga_capture on a reduced 8x6 raster
// (H_TOTAL 16, V_TOTAL 11) with pix_stb every second clock.
module tb_vga_capture;

    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 3;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 2;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int HS0 = HSW + HB;
    localparam int VS0 = VSW + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_stb;
    logic [4:0]  vga_red;
    logic [5:0]  vga_green;
    logic [4:0]  vga_blue;
    logic        h_sync;
    logic        v_sync;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [15:0] pixel_rgb;
    logic        frame_start;
    logic        locked;
    logic        line_err;
    logic        frame_err;
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    vga_capture #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pix_stb(pix_stb),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .h_sync(h_sync), .v_sync(v_sync),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_rgb(pixel_rgb), .frame_start(frame_start), .locked(locked),
        .line_err(line_err), .frame_err(frame_err)
`ifdef VGA_CAPTURE_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // generator position, mirroring the counter values the DUT should hold
    int g_hc, g_vc, g_line_len, g_frame_len, pat;
    bit seen_h_b, seen_v_b;
    int n_px, n_fs, n_le, n_fe, n_crc;
    logic [15:0] cap [0:VA-1][0:HA-1];
    logic [15:0] last_crc, crc_a;
    logic        o_valid, o_fs, o_le, o_fe, o_locked;
    logic [9:0]  o_x, o_y;
    logic [15:0] o_rgb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat_rgb(input int p, input int x, input int y);
        logic [15:0] v;
        if (p == 0)                   v = 16'hF800;
        else if (y == 0 || y == VA-1) v = 16'h07E0;
        else if (x == 0 || x == HA-1) v = 16'h07FF;
        else if (y < VA/2)            v = 16'hF800;
        else                          v = 16'h001F;
        if (p == 2 && x == 3 && y == 2) v[0] = ~v[0];
        return v;
    endfunction

    // one strobe cycle followed by one idle cycle
    task automatic strobe(input logic hs, input logic vs, input logic [15:0] rgb);
        h_sync = hs;
        v_sync = vs;
        {vga_red, vga_green, vga_blue} = rgb;
        pix_stb = 1'b1;
        @(posedge clk); #1;
        o_valid = pixel_valid; o_x = pixel_x; o_y = pixel_y; o_rgb = pixel_rgb;
        o_fs = frame_start; o_le = line_err; o_fe = frame_err; o_locked = locked;
        pix_stb = 1'b0;
        @(posedge clk); #1;
        chk("idle_strobes", {pixel_valid, frame_start, line_err, frame_err}, 4'b0000);
`ifdef VGA_CAPTURE_CRC_EN
        if (crc_valid) begin
            n_crc++;
            last_crc = frame_crc;
        end
`endif
    endtask

    task automatic gen_sample();
        bit last_h, last_v, hs_on, vs_on, in_win, exp_v, exp_le, exp_fe;
        int x, y;
        logic [15:0] rgb;
        last_h = (g_hc == g_line_len - 1);
        last_v = (g_vc == g_frame_len - 1);
        hs_on  = last_h || (g_hc < HSW - 1);
        vs_on  = (last_h && last_v) || (g_vc < VSW - 1) || (g_vc == VSW - 1 && !last_h);
        x      = g_hc - HS0;
        y      = g_vc - VS0;
        in_win = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
        rgb    = in_win ? pat_rgb(pat, x, y) : 16'h0000;
        exp_v  = seen_h_b && seen_v_b && in_win;
        exp_le = last_h && seen_h_b && (g_hc + 1 != HT);
        exp_fe = last_h && last_v && seen_v_b && (g_vc + 1 != VT);
        strobe(!hs_on, !vs_on, rgb);
        chk("pixel_valid", o_valid, exp_v);
        if (exp_v) begin
            chk("pixel_xy_rgb_fs", {o_x, o_y, o_rgb, o_fs}, {10'(x), 10'(y), rgb, (x == 0 && y == 0)});
            cap[y][x] = o_rgb;
        end
        chk("line_err", o_le, exp_le);
        chk("frame_err", o_fe, exp_fe);
        if (exp_le) chk("locked_drop", o_locked, 1'b0);
        n_px += int'(o_valid); n_fs += int'(o_fs); n_le += int'(o_le); n_fe += int'(o_fe);
        if (last_h) begin
            seen_h_b   = 1'b1;
            g_hc       = 0;
            g_line_len = HT;
            if (last_v) begin
                seen_v_b    = 1'b1;
                g_vc        = 0;
                g_frame_len = VT;
            end else begin
                g_vc++;
            end
        end else begin
            g_hc++;
        end
    endtask

    // run up to and including the next vsync edge sample, then check frame totals
    task automatic run_frame(input string tag, input int exp_px, input int exp_fs,
                             input int exp_le, input int exp_fe, input logic exp_lock);
        bit done;
        done = 1'b0;
        n_px = 0; n_fs = 0; n_le = 0; n_fe = 0; n_crc = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            done = (g_hc == g_line_len - 1) && (g_vc == g_frame_len - 1);
            gen_sample();
        end
        chk({tag, "_vedge_reached"}, done, 1'b1);
        chk({tag, "_pixels"}, n_px, exp_px);
        chk({tag, "_frame_starts"}, n_fs, exp_fs);
        chk({tag, "_line_errs"}, n_le, exp_le);
        chk({tag, "_frame_errs"}, n_fe, exp_fe);
        chk({tag, "_locked"}, o_locked, exp_lock);
    endtask

    initial begin
        rst = 1'b1; pix_stb = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
        {vga_red, vga_green, vga_blue} = 16'h0000;
        pat = 0; g_hc = HT - 1; g_vc = VT - 1; g_line_len = HT; g_frame_len = VT;
        seen_h_b = 1'b0; seen_v_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_start,
                              locked, line_err, frame_err}, 64'd0);
`ifdef VGA_CAPTURE_CRC_EN
        chk("reset_crc", {frame_crc, crc_valid}, 17'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // first vsync edge, then three solid frames; lock on the 3rd edge
        run_frame("sync0",  0,  0, 0, 0, 1'b0);
        run_frame("solid1", 48, 1, 0, 0, 1'b0);
        run_frame("solid2", 48, 1, 0, 0, 1'b1);
        run_frame("solid3", 48, 1, 0, 0, 1'b1);

        pat = 1;
        run_frame("border", 48, 1, 0, 0, 1'b1);
        chk("border_0_0", cap[0][0], 16'h07E0);
        chk("border_0_2", cap[2][0], 16'h07FF);
        chk("border_2_1", cap[1][2], 16'hF800);
        chk("border_2_4", cap[4][2], 16'h001F);
        chk("border_7_5", cap[5][7], 16'h07E0);

        g_line_len = HT - 1;
        run_frame("short_line", 48, 1, 1, 0, 1'b0);
        run_frame("relock_l",   48, 1, 0, 0, 1'b1);

        g_frame_len = VT - 1;
        run_frame("short_frame", 48, 1, 0, 1, 1'b0);
        run_frame("relock_f1",   48, 1, 0, 0, 1'b0);
        run_frame("relock_f2",   48, 1, 0, 0, 1'b1);

`ifdef VGA_CAPTURE_CRC_EN
        run_frame("crc_a", 48, 1, 0, 0, 1'b1);
        chk("crc_a_pulses", n_crc, 1);
        crc_a = last_crc;
        run_frame("crc_b", 48, 1, 0, 0, 1'b1);
        chk("crc_b_pulses", n_crc, 1);
        chk("crc_equal", last_crc, crc_a);
        pat = 2;
        run_frame("crc_c", 48, 1, 0, 0, 1'b1);
        chk("crc_c_pulses", n_crc, 1);
        chk("crc_flip_differs", (last_crc != crc_a), 1'b1);
        pat = 1;
`endif

        // asynchronous reset in the middle of an active line
        for (int i = 0; i < 400 && !(g_hc == 6 && g_vc == 5); i++) gen_sample();
        chk("locked_before_rst", locked, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_clear", {pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_start,
                                locked, line_err, frame_err}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen_h_b = 1'b0;
        seen_v_b = 1'b0;
        run_frame("rst_f0", 0,  0, 0, 0, 1'b0);
        run_frame("rst_f1", 48, 1, 0, 0, 1'b0);
        run_frame("rst_f2", 48, 1, 0, 0, 1'b1);

        // h_sync held asserted on an active row: one pass of pixels, no wrap, no edges
        for (int i = 0; i < 400 && !(g_hc == 0 && g_vc == 5); i++) gen_sample();
        n_px = 0;
        n_le = 0;
        for (int i = 0; i < 2100; i++) begin
            strobe(1'b0, 1'b1, 16'h1234);
            n_px += int'(o_valid);
            n_le += int'(o_le);
        end
        chk("hold_pixels", n_px, 8);
        chk("hold_line_errs", n_le, 0);
        strobe(1'b1, 1'b1, 16'h0000);
        chk("release_line_err", o_le, 1'b0);
        strobe(1'b0, 1'b1, 16'h0000);
        chk("saturated_line_err", o_le, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the VGA output produced by the display path: samples RGB565 plus h_sync/v_sync and rebuilds pixel coordinates from the sync edges.
- Emits a per-pixel valid stream and reports timing lock and timing errors.
- Used for on-chip loopback self-test of the display controller / VGA driver pair, and as the front end of a future frame grabber.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- SYNC_ACTIVE, 0, asserted level of h_sync/v_sync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_stb  in  1  pixel-clock enable; inputs sampled only when high
- vga_red  in  5  red
- vga_green  in  6  green
- vga_blue  in  5  blue
- h_sync  in  1  horizontal sync
- v_sync  in  1  vertical sync
- pixel_valid  out  1  one-cycle strobe, active pixel captured
- pixel_x  out  10  column 0..H_ACTIVE-1
- pixel_y  out  10  row 0..V_ACTIVE-1
- pixel_rgb  out  16  {red,green,blue} of captured pixel
- frame_start  out  1  pulse on pixel (0,0)
- locked  out  1  timing locked
- line_err  out  1  pulse, bad line length
- frame_err  out  1  pulse, bad frame length

Behaviour:
- Clock and reset: clk is the clock; rst is asynchronous, active-high.
- Reset: all outputs 0; h_cnt, v_cnt, lock_cnt, seen_h, seen_v cleared; prev_h/prev_v set to the deasserted level.
- Sampling: all state advances only on cycles with pix_stb=1. With pix_stb=0, counters hold and output strobes are 0.
- Edge detection: an hsync edge is sampled h_sync == SYNC_ACTIVE while prev_h != SYNC_ACTIVE; a vsync edge is defined the same way on v_sync.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). h_cnt is 11 bits, v_cnt is 10 bits, both saturating at all-ones.
- Horizontal counting:
  - On an hsync edge: if seen_h and h_cnt+1 != H_TOTAL, pulse line_err. Then h_cnt<=0, seen_h<=1.
  - Otherwise h_cnt<=h_cnt+1.
- Vertical counting:
  - On a vsync edge: if seen_v and v_cnt+1 != V_TOTAL, pulse frame_err. Otherwise, if seen_v, lock_cnt<=min(lock_cnt+1,2). Then v_cnt<=0, seen_v<=1. A vsync edge takes priority over a simultaneous hsync edge for v_cnt.
  - On an hsync edge without a vsync edge: v_cnt<=v_cnt+1.
- Active window: HS0=H_SYNC+H_BP, VS0=V_SYNC+V_BP. A sample is active when seen_h & seen_v & HS0 <= h_cnt < HS0+H_ACTIVE & VS0 <= v_cnt < VS0+V_ACTIVE, evaluated on the counter values before this sample's update.
- Active sample outputs: registered 1 cycle after the strobe cycle.
  - pixel_valid=1.
  - pixel_x=h_cnt-HS0, pixel_y=v_cnt-VS0.
  - pixel_rgb = sampled inputs.
  - frame_start=1 when x=y=0.
- Lock: locked = (lock_cnt==2), i.e. after two consecutive good vsync-to-vsync intervals. Any line_err or frame_err clears lock_cnt to 0 and drops locked the next cycle.
- Boundary cases:
  - The first hsync/vsync edge after reset never raises an error.
  - h_sync held asserted produces no repeated edges.
  - A pixel stream outside the window (porches) gives pixel_valid=0.
  - Saturated counters never wrap and never produce pixel_valid.

Optional Feature:
- VGA_CAPTURE_CRC_EN defined:
  - Adds outputs frame_crc[15:0] and crc_valid.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over pixel_rgb of every pixel_valid pixel in a frame.
  - The accumulator re-inits on frame_start, taking that pixel as its first input.
  - On the cycle after the last active pixel (x=H_ACTIVE-1, y=V_ACTIVE-1), frame_crc is updated and crc_valid pulses 1 cycle.
  - Both outputs reset to 0.
- Not defined: no CRC logic and no extra ports.

Test Plan:
- Nominal 640x480 timing, pix_stb every 2nd clk, three frames of a solid 0xF800 pattern:
  - No errors.
  - locked rises after the 3rd vsync edge.
  - Exactly 307200 pixel_valid pulses per frame.
  - frame_start once per frame, with pixel_x=0, pixel_y=0.
- Border pattern (green rows 0/479, cyan cols 0/639, red top half, blue bottom half):
  - (0,0)=0x07E0, (0,5)=0x07FF, (5,5)=0xF800, (5,300)=0x001F, (639,479)=0x07E0.
- Locked stream, one line shortened to 799 pixels:
  - line_err pulses once at the next hsync edge.
  - locked falls the next cycle and returns after two further good frames.
- vsync interval of 524 lines: frame_err pulses once at the vsync edge; locked=0.
- rst asserted mid-line at h_cnt~300: outputs clear immediately; no error pulses on the first sync edges after release; lock is reacquired after three vsync edges.
- (VGA_CAPTURE_CRC_EN) Two identical frames: crc_valid pulses once per frame with equal frame_crc. Flipping one pixel LSB changes frame_crc.
